// File: rtl/tm4_mb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tm4_mb_sched_pkg
// Description : Shared types and constants for the TM4 macroblock scheduler.
//               Holds the FSM state encoding, the unavailable-edge fill values
//               and a pixel-slice helper for BW-packed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
package tm4_mb_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PRED     = 3'd2,
        ST_WAIT_REC = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Fill values used when the macroblock sits on a frame edge
    localparam int TOP_UNAVAIL  = 127;
    localparam int LEFT_UNAVAIL = 129;

    // Sub-blocks per macroblock and width of the sub-block index
    localparam int NBLK  = 16;
    localparam int IDX_W = 4;

endpackage

// Pixel i of a vector packing pixels of width bw, pixel 0 in the LSBs
`ifndef TM4_PIX
`define TM4_PIX(vec, i, bw) vec[(i)*(bw) +: (bw)]
`endif
`default_nettype wire

// File: rtl/tm4_mb_sched_tm4.sv
`default_nettype none
// ============================================================================
// Module      : tm4_mb_sched_tm4
// Description : Combinational TrueMotion 4x4 predictor.
//               pred(r,c) = clamp(top[c] + left[r] - top_left, 0, 2^BW-1)
// Revision    : 1.0 - initial release
// ============================================================================
module tm4_mb_sched_tm4 #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE*BIT_WIDTH-1:0]            i_top_px,
    input  logic [BLOCK_SIZE*BIT_WIDTH-1:0]            i_left_px,
    input  logic [BIT_WIDTH-1:0]                       i_tl_px,
    output logic [BLOCK_SIZE*BLOCK_SIZE*BIT_WIDTH-1:0] o_pred_px
);

    // Two extra bits: one for the sum carry, one for the sign
    localparam int                    SW   = BIT_WIDTH + 2;
    localparam logic signed [SW-1:0]  MAXV = SW'((1 << BIT_WIDTH) - 1);

    generate
        for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
            for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
                logic signed [SW-1:0] w_sum;

                assign w_sum = $signed({2'b00, `TM4_PIX(i_top_px, c, BIT_WIDTH)})
                             + $signed({2'b00, `TM4_PIX(i_left_px, r, BIT_WIDTH)})
                             - $signed({2'b00, i_tl_px});

                assign `TM4_PIX(o_pred_px, r*BLOCK_SIZE + c, BIT_WIDTH) =
                    (w_sum < 0)    ? '0 :
                    (w_sum > MAXV) ? '1 : w_sum[BIT_WIDTH-1:0];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tm4_mb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tm4_mb_sched
// Description : Walks the 16 4x4 luma sub-blocks of a macroblock in raster
//               order, builds TM4 neighbours from the MB edges and earlier
//               reconstructions, issues predictions and waits for recon.
// Revision    : 1.0 - initial release
// ============================================================================
module tm4_mb_sched
    import tm4_mb_sched_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int MB_SIZE    = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            mb_top_avail,
    input  logic                            mb_left_avail,
    input  logic [BIT_WIDTH*MB_SIZE-1:0]    mb_top,
    input  logic [BIT_WIDTH*MB_SIZE-1:0]    mb_left,
    input  logic [BIT_WIDTH-1:0]            mb_top_left,
    output logic                            busy,
    output logic                            done,
    output logic                            pred_valid,
    input  logic                            pred_ready,
    output logic [IDX_W-1:0]                pred_idx,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred_block,
    input  logic                            rec_valid,
    output logic                            rec_ready,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] rec_block
);

    localparam int BW = BIT_WIDTH;
    localparam int BS = BLOCK_SIZE;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pred_valid_q, pred_valid_d;
    logic               rec_ready_q, rec_ready_d;

    // Bottom row of the most recent block in each column (starts as MB top edge)
    logic [BW-1:0]      top_edge_q [MB_SIZE];
    logic [BW-1:0]      top_edge_d [MB_SIZE];
    // Column left of the macroblock, consumed at each row start
    logic [BW-1:0]      left_col_q [MB_SIZE];
    logic [BW-1:0]      left_col_d [MB_SIZE];
    // Left neighbour column of the current sub-block
    logic [BW-1:0]      left_cur_q [BS];
    logic [BW-1:0]      left_cur_d [BS];
    logic [BW-1:0]      corner_q, corner_d;
    logic [BW-1:0]      tl_q, tl_d;

    logic [1:0]         w_bx;
    logic [1:0]         w_by;
    logic [BS*BW-1:0]   w_top_px;
    logic [BS*BW-1:0]   w_left_px;
    logic               w_rec_unused;

    assign w_bx = idx_q[1:0];
    assign w_by = idx_q[3:2];

    // Only row 3 and column 3 of the reconstruction feed later neighbours
    assign w_rec_unused = ^rec_block;

    // Next-state, edge-state updates and registered output decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        corner_d   = corner_q;
        tl_d       = tl_q;
        top_edge_d = top_edge_q;
        left_col_d = left_col_q;
        left_cur_d = left_cur_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    for (int k = 0; k < MB_SIZE; k++) begin
                        top_edge_d[k] = mb_top_avail  ? mb_top[k*BW +: BW]  : BW'(TOP_UNAVAIL);
                        left_col_d[k] = mb_left_avail ? mb_left[k*BW +: BW] : BW'(LEFT_UNAVAIL);
                    end
                    corner_d = !mb_top_avail  ? BW'(TOP_UNAVAIL)  :
                               !mb_left_avail ? BW'(LEFT_UNAVAIL) : mb_top_left;
                end
            end
            ST_LOAD: begin
                // Row-start neighbours for block 0
                state_d = ST_PRED;
                for (int k = 0; k < BS; k++) begin
                    left_cur_d[k] = left_col_q[k];
                end
                tl_d = corner_q;
            end
            ST_PRED: begin
                if (pred_ready) begin
                    state_d = ST_WAIT_REC;
                end
            end
            ST_WAIT_REC: begin
                if (rec_valid) begin
                    // Corner for the next block is the old top-edge pixel,
                    // read before this cycle's overwrite takes effect
                    tl_d = top_edge_q[{w_bx, 2'd3}];
                    for (int k = 0; k < BS; k++) begin
                        top_edge_d[{w_bx, 2'(k)}] = rec_block[((BS-1)*BS + k)*BW +: BW];
                        left_cur_d[k]             = rec_block[(k*BS + BS-1)*BW +: BW];
                    end
                    if (idx_q == IDX_W'(NBLK-1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PRED;
                        idx_d   = idx_q + 1'b1;
                        if (w_bx == 2'd3) begin
                            // Next block starts a new row: neighbours from MB left edge
                            for (int k = 0; k < BS; k++) begin
                                left_cur_d[k] = left_col_q[{w_by + 2'd1, 2'(k)}];
                            end
                            tl_d = left_col_q[{w_by, 2'd3}];
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_LOAD) || (state_d == ST_PRED) || (state_d == ST_WAIT_REC);
        pred_valid_d = (state_d == ST_PRED);
        rec_ready_d  = (state_d == ST_WAIT_REC);
        done_d       = (state_d == ST_DONE);
    end

    // State, index, edge registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pred_valid_q <= 1'b0;
            rec_ready_q  <= 1'b0;
            corner_q     <= '0;
            tl_q         <= '0;
            for (int k = 0; k < MB_SIZE; k++) begin
                top_edge_q[k] <= '0;
                left_col_q[k] <= '0;
            end
            for (int k = 0; k < BS; k++) begin
                left_cur_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pred_valid_q <= pred_valid_d;
            rec_ready_q  <= rec_ready_d;
            corner_q     <= corner_d;
            tl_q         <= tl_d;
            top_edge_q   <= top_edge_d;
            left_col_q   <= left_col_d;
            left_cur_q   <= left_cur_d;
        end
    end

    // Pack the current sub-block neighbours for the predictor
    always_comb begin
        w_top_px  = '0;
        w_left_px = '0;
        for (int k = 0; k < BS; k++) begin
            w_top_px[k*BW +: BW]  = top_edge_q[{w_bx, 2'(k)}];
            w_left_px[k*BW +: BW] = left_cur_q[k];
        end
    end

    tm4_mb_sched_tm4 #(
        .BIT_WIDTH  (BIT_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_tm4 (
        .i_top_px   (w_top_px),
        .i_left_px  (w_left_px),
        .i_tl_px    (tl_q),
        .o_pred_px  (pred_block)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign pred_valid = pred_valid_q;
    assign rec_ready  = rec_ready_q;
    assign pred_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tm4_mb_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tm4_mb_sched
// Description : Self-checking bench for tm4_mb_sched. A table of macroblock
//               edge settings with hand-computed block-0 predictions, plus a
//               picture-buffer reference for every later sub-block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm4_mb_sched;

    localparam int BW = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           mb_top_avail = 1'b0;
    logic           mb_left_avail = 1'b0;
    logic [BW*16-1:0] mb_top = '0;
    logic [BW*16-1:0] mb_left = '0;
    logic [BW-1:0]  mb_top_left = '0;
    logic           busy;
    logic           done;
    logic           pred_valid;
    logic           pred_ready = 1'b0;
    logic [3:0]     pred_idx;
    logic [BW*16-1:0] pred_block;
    logic           rec_valid = 1'b0;
    logic           rec_ready;
    logic [BW*16-1:0] rec_block = '0;

    tm4_mb_sched #(.BIT_WIDTH(8), .BLOCK_SIZE(4), .MB_SIZE(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mb_top_avail (mb_top_avail),
        .mb_left_avail(mb_left_avail),
        .mb_top       (mb_top),
        .mb_left      (mb_left),
        .mb_top_left  (mb_top_left),
        .busy         (busy),
        .done         (done),
        .pred_valid   (pred_valid),
        .pred_ready   (pred_ready),
        .pred_idx     (pred_idx),
        .pred_block   (pred_block),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_block    (rec_block)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reconstructed picture with a one-pixel border: P(y,x) = pic[y+1][x+1]
    int pic [17][17];
    int top_px [16];
    int left_px [16];

    typedef struct {
        bit ta;
        bit la;
        int top;
        int left;
        int tl;
        int exp0;
        int mode;
        bit bp;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_pred(input int b);
        logic [127:0] v;
        int bx, by, t, l, tl, p;
        bx = b % 4;
        by = b / 4;
        v  = '0;
        tl = pic[4*by][4*bx];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t = pic[4*by][4*bx+c+1];
                l = pic[4*by+r+1][4*bx];
                p = t + l - tl;
                if (p < 0) p = 0;
                if (p > 255) p = 255;
                v[(r*4+c)*8 +: 8] = 8'(p);
            end
        end
        return v;
    endfunction

    function automatic logic [127:0] make_rec(input logic [127:0] p, input int mode, input int b);
        logic [127:0] v;
        v = p;
        if (mode == 1 && b == 0) begin
            v[96  +: 8] = 8'd10;
            v[104 +: 8] = 8'd20;
            v[112 +: 8] = 8'd30;
            v[120 +: 8] = 8'd40;
        end else if (mode == 2) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    v[(r*4+c)*8 +: 8] = 8'(int'(p[(r*4+c)*8 +: 8]) + b*11 + r*5 + c*3);
        end
        return v;
    endfunction

    task automatic init_mb(input bit ta, input bit la, input int tl);
        mb_top_avail  = ta;
        mb_left_avail = la;
        mb_top_left   = 8'(tl);
        for (int x = 0; x < 16; x++) begin
            mb_top[x*8 +: 8]  = 8'(top_px[x]);
            mb_left[x*8 +: 8] = 8'(left_px[x]);
            pic[0][x+1] = ta ? top_px[x] : 127;
            pic[x+1][0] = la ? left_px[x] : 129;
        end
        pic[0][0] = !ta ? 127 : (!la ? 129 : tl);
    endtask

    task automatic uniform_px(input int t, input int l);
        for (int x = 0; x < 16; x++) begin
            top_px[x]  = t;
            left_px[x] = l;
        end
    endtask

    // mode: 0 recon=pred, 1 block-0 bottom row overridden, 2 perturbed recon
    task automatic run_mb(input int mode, input bit bp, input int abort_idx, input int exp0);
        logic [127:0] exp, rec, held;
        int wait_n, bx, by;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 128'(busy), 128'(1));
        chk("pv_low_in_load", 128'(pred_valid), 128'(0));
        step();
        chk("pv_latency", 128'(pred_valid), 128'(1));
        for (int b = 0; b < 16; b++) begin
            wait_n = 0;
            while (!pred_valid && wait_n < 20) begin
                step();
                wait_n++;
            end
            if (!pred_valid) begin
                chk("pred_valid_timeout", 128'(pred_valid), 128'(1));
                return;
            end
            exp = model_pred(b);
            chk("pred_idx", 128'(pred_idx), 128'(b));
            chk("pred_block", pred_block, exp);
            chk("busy_mid", 128'(busy), 128'(1));
            if (b == 0 && exp0 >= 0) chk("blk0_hand", pred_block, {16{8'(exp0)}});
            if (mode == 1 && b == 1) chk("dep_blk1_px30", 128'(pred_block[96 +: 8]), 128'(40));
            if (mode == 1 && b == 4) chk("dep_blk4_row0", 128'(pred_block[31:0]), 128'(32'h281E140A));
            if (mode == 1 && b == 5) chk("dep_blk5_all40", pred_block, {16{8'd40}});

            if (bp && b == 2) begin
                held = pred_block;
                for (int k = 0; k < 5; k++) begin
                    rec_valid = 1'b1;
                    rec_block = ~exp;
                    start     = 1'b1;
                    step();
                    chk("bp_valid", 128'(pred_valid), 128'(1));
                    chk("bp_idx", 128'(pred_idx), 128'(2));
                    chk("bp_block", pred_block, held);
                    chk("bp_rec_ready", 128'(rec_ready), 128'(0));
                end
                start = 1'b0;
            end

            pred_ready = 1'b1;
            step();
            pred_ready = 1'b0;
            rec_valid  = 1'b0;
            chk("wait_rec_ready", 128'(rec_ready), 128'(1));
            chk("wait_pv_low", 128'(pred_valid), 128'(0));

            if (b == abort_idx) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", 128'(busy), 128'(0));
                chk("abort_rec_ready", 128'(rec_ready), 128'(0));
                chk("abort_pv", 128'(pred_valid), 128'(0));
                chk("abort_idx", 128'(pred_idx), 128'(0));
                chk("abort_done", 128'(done), 128'(0));
                step();
                rst_n = 1'b1;
                step();
                chk("abort_no_done", 128'(done), 128'(0));
                return;
            end

            rec = make_rec(exp, mode, b);
            bx  = b % 4;
            by  = b / 4;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    pic[4*by+r+1][4*bx+c+1] = int'(rec[(r*4+c)*8 +: 8]);
            rec_valid = 1'b1;
            rec_block = rec;
            step();
            rec_valid = 1'b0;

            if (b == 15) begin
                chk("done_pulse", 128'(done), 128'(1));
                chk("done_busy_low", 128'(busy), 128'(0));
                chk("done_rec_ready", 128'(rec_ready), 128'(0));
                start = 1'b1;
                step();
                start = 1'b0;
                chk("done_one_cycle", 128'(done), 128'(0));
                chk("idle_busy", 128'(busy), 128'(0));
                step();
                chk("start_in_done_ignored", 128'(busy), 128'(0));
            end else begin
                chk("not_done_yet", 128'(done), 128'(0));
            end
        end
    endtask

    initial begin
        //          ta  la  top  left  tl   exp0 mode bp
        tbl[0] = '{1'b1, 1'b1, 100, 100, 100, 100, 1, 1'b0};
        tbl[1] = '{1'b0, 1'b0,  33,  33,  33, 129, 0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 250, 250,  10, 255, 0, 1'b1};
        tbl[3] = '{1'b1, 1'b1,   5,   5, 200,   0, 2, 1'b0};
        tbl[4] = '{1'b1, 1'b0,  50,  33,  33,  50, 2, 1'b0};
        tbl[5] = '{1'b0, 1'b1,  33,  60,  33,  60, 0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 200,  30, 100, 130, 2, 1'b0};

        #2;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_pred_valid", 128'(pred_valid), 128'(0));
        chk("rst_rec_ready", 128'(rec_ready), 128'(0));
        chk("rst_pred_idx", 128'(pred_idx), 128'(0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            uniform_px(tbl[i].top, tbl[i].left);
            init_mb(tbl[i].ta, tbl[i].la, tbl[i].tl);
            run_mb(tbl[i].mode, tbl[i].bp, -1, tbl[i].exp0);
            step();
        end

        // Non-uniform edges: distinct corner and per-pixel top/left values
        for (int x = 0; x < 16; x++) begin
            top_px[x]  = x*13 + 7;
            left_px[x] = 200 - x*9;
        end
        init_mb(1'b1, 1'b1, 77);
        run_mb(2, 1'b0, -1, -1);
        step();

        // Reset while waiting for recon of block 7, then a full clean MB
        uniform_px(90, 140);
        init_mb(1'b1, 1'b1, 60);
        run_mb(2, 1'b0, 7, 170);
        for (int x = 0; x < 16; x++) begin
            top_px[x]  = 255 - x*11;
            left_px[x] = x*7 + 3;
        end
        init_mb(1'b1, 1'b1, 128);
        run_mb(0, 1'b0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
